// File: rtl/bus_arbiter_if.sv
// Bus-arbiter signal bundle: MCU/SPI and CPU requests in, RAM strobes and slot status out.
// The arbiter connects through the slave modport; the requesting side uses master.
interface bus_arbiter_if;
    logic       spi_req_i;
    logic       spi_rw_ni;
    logic       cpu_rw_ni;
    logic       cpu_halt_i;
    logic       spi_ack_o;
    logic       clk_cpu_o;
    logic       cpu_ready_o;
    logic       cpu_en_no;
    logic [1:0] owner_o;
    logic       ram_oe_no;
    logic       ram_we_no;
    logic       video_strobe_o;
    logic [3:0] cycle_o;

    modport slave (
        input  spi_req_i, spi_rw_ni, cpu_rw_ni, cpu_halt_i,
        output spi_ack_o, clk_cpu_o, cpu_ready_o, cpu_en_no, owner_o,
               ram_oe_no, ram_we_no, video_strobe_o, cycle_o
    );

    modport master (
        output spi_req_i, spi_rw_ni, cpu_rw_ni, cpu_halt_i,
        input  spi_ack_o, clk_cpu_o, cpu_ready_o, cpu_en_no, owner_o,
               ram_oe_no, ram_we_no, video_strobe_o, cycle_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Time-sliced RAM arbiter: a 16-clock frame split into VIDEO (0-3), SPI (4-7) and CPU (8-15) slots.
// Every output is computed from the next cycle number and registered, so nothing is combinational from inputs.
module bus_arbiter (
    input  logic          clk_16_i,
    input  logic          reset_ai,
    bus_arbiter_if.slave  bus
);
    localparam logic [1:0] OWN_VIDEO = 2'd0;
    localparam logic [1:0] OWN_SPI   = 2'd1;
    localparam logic [1:0] OWN_CPU   = 2'd2;
    localparam logic [1:0] OWN_NONE  = 2'd3;

    logic       run_q,      run_d;
    logic [3:0] cycle_q,    cycle_d;
    logic       grant_q,    grant_d;
    logic       spi_rw_q,   spi_rw_d;
    logic       cpu_rw_q,   cpu_rw_d;
    logic       ready_q,    ready_d;
    logic [1:0] owner_q,    owner_d;
    logic       oe_n_q,     oe_n_d;
    logic       we_n_q,     we_n_d;
    logic       ack_q,      ack_d;
    logic       strobe_q,   strobe_d;
    logic       clk_cpu_q,  clk_cpu_d;
    logic       cpu_en_n_q, cpu_en_n_d;

    always_comb begin
        run_d   = 1'b1;
        // The first edge after reset opens cycle 0 rather than advancing past it.
        cycle_d = run_q ? cycle_q + 4'd1 : 4'd0;

        ready_d  = (cycle_d == 4'd0)  ? ~bus.cpu_halt_i : ready_q;
        grant_d  = (cycle_d == 4'd4)  ? bus.spi_req_i   : grant_q;
        spi_rw_d = (cycle_d == 4'd4)  ? bus.spi_rw_ni   : spi_rw_q;
        cpu_rw_d = (cycle_d == 4'd12) ? bus.cpu_rw_ni   : cpu_rw_q;

        if (cycle_d[3])
            owner_d = OWN_CPU;
        else if (cycle_d[2])
            owner_d = grant_d ? OWN_SPI : OWN_NONE;
        else
            owner_d = OWN_VIDEO;

        oe_n_d = 1'b1;
        if (cycle_d >= 4'd1 && cycle_d <= 4'd3)
            oe_n_d = 1'b0;
        if (cycle_d >= 4'd5 && cycle_d <= 4'd7 && grant_d && spi_rw_d)
            oe_n_d = 1'b0;
        if (cycle_d >= 4'd13 && cpu_rw_d)
            oe_n_d = 1'b0;

        // Write strobes skip each slot's first and last cycle for address setup/hold.
        we_n_d = 1'b1;
        if (cycle_d >= 4'd5 && cycle_d <= 4'd6 && grant_d && !spi_rw_d)
            we_n_d = 1'b0;
        if (cycle_d >= 4'd13 && cycle_d <= 4'd14 && !cpu_rw_d && ready_d)
            we_n_d = 1'b0;

        ack_d      = (cycle_d == 4'd7) && grant_d;
        strobe_d   = (cycle_d == 4'd3);
        clk_cpu_d  = (cycle_d >= 4'd12);
        cpu_en_n_d = ~cycle_d[3];
    end

    always_ff @(posedge clk_16_i or posedge reset_ai) begin
        if (reset_ai) begin
            run_q      <= 1'b0;
            cycle_q    <= 4'd0;
            grant_q    <= 1'b0;
            spi_rw_q   <= 1'b1;
            cpu_rw_q   <= 1'b1;
            ready_q    <= 1'b0;
            owner_q    <= OWN_NONE;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            ack_q      <= 1'b0;
            strobe_q   <= 1'b0;
            clk_cpu_q  <= 1'b0;
            cpu_en_n_q <= 1'b1;
        end else begin
            run_q      <= run_d;
            cycle_q    <= cycle_d;
            grant_q    <= grant_d;
            spi_rw_q   <= spi_rw_d;
            cpu_rw_q   <= cpu_rw_d;
            ready_q    <= ready_d;
            owner_q    <= owner_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            ack_q      <= ack_d;
            strobe_q   <= strobe_d;
            clk_cpu_q  <= clk_cpu_d;
            cpu_en_n_q <= cpu_en_n_d;
        end
    end

    assign bus.cycle_o        = cycle_q;
    assign bus.owner_o        = owner_q;
    assign bus.ram_oe_no      = oe_n_q;
    assign bus.ram_we_no      = we_n_q;
    assign bus.spi_ack_o      = ack_q;
    assign bus.video_strobe_o = strobe_q;
    assign bus.clk_cpu_o      = clk_cpu_q;
    assign bus.cpu_ready_o    = ready_q;
    assign bus.cpu_en_no      = cpu_en_n_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: per-cycle slot-map scoreboard, frame-level vector table,
// and hand-written sequences for late requests, back-to-back grants and mid-access reset.
`timescale 1ns/1ps
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bus_arbiter_if bif();

    bus_arbiter dut (
        .clk_16_i (clk),
        .reset_ai (rst),
        .bus      (bif.slave)
    );

    always #31 clk = ~clk;

    typedef struct {
        logic [3:0] cyc;
        logic [1:0] owner;
        bit oe_n, we_n, ack, strobe, clkc, rdy, en_n;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit req; int req_cyc; bit spi_rw; bit halt; bit cpu_rw;
        int exp_ack; int exp_oe; int exp_we; int exp_rdy;
    } vec_t;
    vec_t vecs[8];

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    bit m_run = 0;
    int m_cyc = 0;
    bit m_grant = 0, m_srw = 1, m_crw = 1, m_ready = 0;

    int t_ack, t_oe, t_we, t_rdy;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cycle"},  bif.cycle_o, 0);
        chk({tag, "_owner"},  bif.owner_o, 3);
        chk({tag, "_oe"},     bif.ram_oe_no, 1);
        chk({tag, "_we"},     bif.ram_we_no, 1);
        chk({tag, "_en"},     bif.cpu_en_no, 1);
        chk({tag, "_clkcpu"}, bif.clk_cpu_o, 0);
        chk({tag, "_rdy"},    bif.cpu_ready_o, 0);
        chk({tag, "_ack"},    bif.spi_ack_o, 0);
        chk({tag, "_strobe"}, bif.video_strobe_o, 0);
    endtask

    // Predict the outputs of the coming edge, push them, clock, then pop and compare.
    task automatic step();
        exp_t e;
        int n;
        n = m_run ? (m_cyc + 1) % 16 : 0;
        if (n == 0)  m_ready = !bif.cpu_halt_i;
        if (n == 4)  begin m_grant = bif.spi_req_i; m_srw = bif.spi_rw_ni; end
        if (n == 12) m_crw = bif.cpu_rw_ni;
        e.cyc    = 4'(n);
        e.owner  = (n < 4) ? 2'd0 : (n < 8) ? (m_grant ? 2'd1 : 2'd3) : 2'd2;
        e.oe_n   = !((n >= 1 && n <= 3) || (n >= 5 && n <= 7 && m_grant && m_srw) || (n >= 13 && m_crw));
        e.we_n   = !((n == 5 || n == 6) && m_grant && !m_srw) && !((n == 13 || n == 14) && !m_crw && m_ready);
        e.ack    = (n == 7) && m_grant;
        e.strobe = (n == 3);
        e.clkc   = (n >= 12);
        e.rdy    = m_ready;
        e.en_n   = (n < 8);
        m_cyc = n;
        m_run = 1;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("cycle",  bif.cycle_o,        e.cyc);
        chk("owner",  bif.owner_o,        e.owner);
        chk("oe_n",   bif.ram_oe_no,      e.oe_n);
        chk("we_n",   bif.ram_we_no,      e.we_n);
        chk("ack",    bif.spi_ack_o,      e.ack);
        chk("strobe", bif.video_strobe_o, e.strobe);
        chk("clkcpu", bif.clk_cpu_o,      e.clkc);
        chk("ready",  bif.cpu_ready_o,    e.rdy);
        chk("en_n",   bif.cpu_en_no,      e.en_n);
        chk("oe_we_excl", (bif.ram_oe_no | bif.ram_we_no), 1);
        t_ack += bif.spi_ack_o;
        t_oe  += !bif.ram_oe_no;
        t_we  += !bif.ram_we_no;
        t_rdy += bif.cpu_ready_o;
    endtask

    task automatic clear_tally();
        t_ack = 0; t_oe = 0; t_we = 0; t_rdy = 0;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        bif.cpu_halt_i = v.halt;
        bif.cpu_rw_ni  = v.cpu_rw;
        bif.spi_rw_ni  = v.spi_rw;
        clear_tally();
        for (int k = 0; k < 16; k++) begin
            step();
            if (v.req && k == v.req_cyc) bif.spi_req_i = 1'b1;
            if (bif.spi_ack_o) bif.spi_req_i = 1'b0;
        end
        chk($sformatf("vec%0d_ack", idx), t_ack, v.exp_ack);
        chk($sformatf("vec%0d_oe",  idx), t_oe,  v.exp_oe);
        chk($sformatf("vec%0d_we",  idx), t_we,  v.exp_we);
        chk($sformatf("vec%0d_rdy", idx), t_rdy, v.exp_rdy);
        $display("frame %0d: req=%0b spi_rw=%0b halt=%0b cpu_rw=%0b -> acks=%0d oe_low=%0d we_low=%0d rdy=%0d",
                 idx, v.req, v.spi_rw, v.halt, v.cpu_rw, t_ack, t_oe, t_we, t_rdy);
    endtask

    initial begin
        int n;
        //          req cyc rw halt crw  ack oe we rdy
        vecs[0] = '{0, 0, 1, 0, 1,  0, 6, 0, 16};
        vecs[1] = '{0, 0, 1, 0, 1,  0, 6, 0, 16};
        vecs[2] = '{0, 0, 1, 0, 1,  0, 6, 0, 16};
        vecs[3] = '{1, 2, 0, 0, 1,  1, 6, 2, 16};
        vecs[4] = '{1, 0, 1, 0, 0,  1, 6, 2, 16};
        vecs[5] = '{0, 0, 1, 1, 0,  0, 3, 0, 0};
        vecs[6] = '{1, 3, 0, 0, 0,  1, 3, 4, 16};
        vecs[7] = '{1, 1, 1, 1, 1,  1, 9, 0, 0};

        bif.spi_req_i = 0; bif.spi_rw_ni = 1; bif.cpu_rw_ni = 1; bif.cpu_halt_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst_init");
        $display("reset: cycle=%0d owner=%0d oe_n=%0b", bif.cycle_o, bif.owner_o, bif.ram_oe_no);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

        // Late request at cycle 5 waits a full frame.
        for (int k = 0; k < 6; k++) step();
        bif.spi_rw_ni = 1'b1;
        bif.spi_req_i = 1'b1;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (bif.spi_ack_o) break;
        end
        chk("late_req_latency", n, 18);
        $display("late request: ack after %0d clocks", n);
        bif.spi_req_i = 1'b0;
        for (int k = 0; k < 8; k++) step();
        chk("late_req_end_cycle", bif.cycle_o, 15);

        // Request held through its ack is re-granted at the next cycle 4.
        bif.spi_rw_ni = 1'b0;
        bif.spi_req_i = 1'b1;
        clear_tally();
        for (int k = 0; k < 32; k++) step();
        bif.spi_req_i = 1'b0;
        chk("back_to_back_acks", t_ack, 2);
        $display("back-to-back: acks=%0d we_low=%0d", t_ack, t_we);

        // Reset in the middle of a granted SPI read.
        bif.spi_rw_ni = 1'b1;
        bif.spi_req_i = 1'b1;
        for (int k = 0; k < 7; k++) step();
        chk("mid_read_cycle", bif.cycle_o, 6);
        chk("mid_read_oe", bif.ram_oe_no, 0);
        rst = 1'b1;
        #1;
        check_reset_state("rst_async");
        bif.spi_req_i = 1'b0;
        sb_q.delete();
        m_run = 0; m_grant = 0; m_srw = 1; m_crw = 1; m_ready = 0;
        @(posedge clk);
        #1;
        check_reset_state("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        clear_tally();
        for (int k = 0; k < 16; k++) step();
        chk("post_reset_acks", t_ack, 0);
        $display("mid-access reset: acks after restart=%0d", t_ack);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
